// File: rtl/nbank_pp_pkg.sv
// nbank_pp_pkg
// Shared definitions for the N-bank ping-pong buffer:
//   - bank_state_t : per-bank lifecycle (EMPTY -> FILLING -> FULL -> EMPTY)
//   - default values for DATA_WIDTH / DEPTH / NUM_BANKS
//   - pp_bank_w()  : bank index width, never less than one bit
package nbank_pp_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    localparam int PP_DATA_WIDTH = 16;
    localparam int PP_DEPTH      = 8;
    localparam int PP_NUM_BANKS  = 2;

    function automatic int pp_bank_w(input int num_banks);
        return (num_banks > 2) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/nbank_pingpong_buffer_ram.sv
// pp_bank_ram
// Simple dual-port RAM for one bank: one synchronous write port and one
// registered read port. Contents are deliberately not reset.
// Ports:
//   clk   in  clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write word
//   re    in  read enable (rdata only updates when high)
//   raddr in  read address
//   rdata out registered read word
module pp_bank_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/nbank_pingpong_buffer.sv
// nbank_pingpong_buffer
// Rotating multi-bank buffer: a producer fills banks in order, a consumer
// reads any word of the oldest full bank as often as it likes and then
// releases it with rd_done, returning the bank to the producer.
// Optional feature: define PP_ERR_EN to add a sticky err output flagging
// rd_en / rd_done issued while no bank is readable.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   wr_valid/ready write handshake, wr_data write word
//   rd_valid       current read bank is full
//   rd_en, rd_addr read request and word address
//   rd_data        read word, rd_data_valid one cycle after an accepted read
//   rd_done        release the current read bank
//   wr_bank, rd_bank, full_count  status
//   err            (PP_ERR_EN only) sticky misuse flag
module nbank_pingpong_buffer
    import nbank_pp_pkg::*;
#(
    parameter int DATA_WIDTH = PP_DATA_WIDTH,
    parameter int DEPTH      = PP_DEPTH,
    parameter int NUM_BANKS  = PP_NUM_BANKS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    output logic                                  rd_valid,
    input  logic                                  rd_en,
    input  logic [$clog2(DEPTH)-1:0]              rd_addr,
    output logic [DATA_WIDTH-1:0]                 rd_data,
    output logic                                  rd_data_valid,
    input  logic                                  rd_done,
    output logic [pp_bank_w(NUM_BANKS)-1:0]       wr_bank,
    output logic [pp_bank_w(NUM_BANKS)-1:0]       rd_bank,
    output logic [$clog2(NUM_BANKS+1)-1:0]        full_count
`ifdef PP_ERR_EN
    ,
    output logic                                  err
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BANK_W = pp_bank_w(NUM_BANKS);
    localparam int CNT_W  = $clog2(NUM_BANKS + 1);

    logic [BANK_W-1:0]     wr_ptr_reg;
    logic [BANK_W-1:0]     rd_ptr_reg;
    logic [ADDR_W-1:0]     wr_addr_reg;
    logic [CNT_W-1:0]      full_count_reg;

    // Read-path bookkeeping: which bank's RAM register holds the last word,
    // whether the last accepted read was out of range, and whether any read
    // has landed since reset (RAM registers themselves are not reset).
    logic [BANK_W-1:0]     rd_sel_reg;
    logic                  rd_zero_reg;
    logic                  rd_have_reg;
    logic                  rd_data_valid_reg;

    logic [NUM_BANKS-1:0]  bank_full;
    logic [DATA_WIDTH-1:0] ram_q [NUM_BANKS];

    logic                  wr_fire;
    logic                  wr_last;
    logic                  rd_fire;
    logic                  rd_release;
    logic                  rd_oob;
    logic [ADDR_W:0]       rd_addr_ext;

    assign wr_ready    = ~bank_full[wr_ptr_reg];
    assign rd_valid    = bank_full[rd_ptr_reg];
    assign wr_fire     = wr_valid & wr_ready;
    assign wr_last     = (wr_addr_reg == ADDR_W'(DEPTH - 1));
    assign rd_fire     = rd_en & rd_valid;
    assign rd_release  = rd_done & rd_valid;
    assign rd_addr_ext = {1'b0, rd_addr};
    assign rd_oob      = (rd_addr_ext >= (ADDR_W + 1)'(DEPTH));

    // Per-bank state machine and storage. Writes only target non-full banks
    // and releases only full banks, so the two never hit one bank together.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            bank_state_t state_reg;
            logic        bank_we;
            logic        bank_re;

            assign bank_we = wr_fire & (wr_ptr_reg == BANK_W'(gi));
            assign bank_re = rd_fire & ~rd_oob & (rd_ptr_reg == BANK_W'(gi));
            assign bank_full[gi] = (state_reg == FULL);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= EMPTY;
                end else if (bank_we) begin
                    state_reg <= wr_last ? FULL : FILLING;
                end else if (rd_release && (rd_ptr_reg == BANK_W'(gi))) begin
                    state_reg <= EMPTY;
                end
            end

            pp_bank_ram #(
                .DATA_WIDTH(DATA_WIDTH),
                .DEPTH     (DEPTH)
            ) u_ram (
                .clk  (clk),
                .we   (bank_we),
                .waddr(wr_addr_reg),
                .wdata(wr_data),
                .re   (bank_re),
                .raddr(rd_addr),
                .rdata(ram_q[gi])
            );
        end
    endgenerate

    // Write pointer / address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            wr_addr_reg <= '0;
        end else if (wr_fire) begin
            if (wr_last) begin
                wr_addr_reg <= '0;
                wr_ptr_reg  <= (wr_ptr_reg == BANK_W'(NUM_BANKS - 1)) ?
                               '0 : wr_ptr_reg + BANK_W'(1);
            end else begin
                wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
            end
        end
    end

    // Read pointer, read-data tracking and full bank count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg        <= '0;
            rd_sel_reg        <= '0;
            rd_zero_reg       <= 1'b0;
            rd_have_reg       <= 1'b0;
            rd_data_valid_reg <= 1'b0;
            full_count_reg    <= '0;
        end else begin
            rd_data_valid_reg <= rd_fire;
            if (rd_fire) begin
                rd_sel_reg  <= rd_ptr_reg;
                rd_zero_reg <= rd_oob;
                rd_have_reg <= 1'b1;
            end
            if (rd_release) begin
                rd_ptr_reg <= (rd_ptr_reg == BANK_W'(NUM_BANKS - 1)) ?
                              '0 : rd_ptr_reg + BANK_W'(1);
            end
            // Net change when a bank completes and another is released together
            if (wr_fire && wr_last && !rd_release) begin
                full_count_reg <= full_count_reg + CNT_W'(1);
            end else if (rd_release && !(wr_fire && wr_last)) begin
                full_count_reg <= full_count_reg - CNT_W'(1);
            end
        end
    end

    assign rd_data       = (rd_have_reg && !rd_zero_reg) ? ram_q[rd_sel_reg] : '0;
    assign rd_data_valid = rd_data_valid_reg;
    assign wr_bank       = wr_ptr_reg;
    assign rd_bank       = rd_ptr_reg;
    assign full_count    = full_count_reg;

`ifdef PP_ERR_EN
    logic err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if ((rd_en || rd_done) && !rd_valid) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: doc/nbank_pingpong_buffer.md
NBANK_PINGPONG_BUFFER -- requirements
Module: nbank_pingpong_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning words per bank (>=2).
REQ-003 SHALL have parameter NUM_BANKS, default 2, meaning number of rotating banks (>=2).
REQ-004 SHALL derive localparams ADDR_W = $clog2(DEPTH), BANK_W = max(1,$clog2(NUM_BANKS)), CNT_W = $clog2(NUM_BANKS+1).
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports wr_valid  in  1  write request; wr_ready  out  1  write accepted when high; wr_data  in  DATA_WIDTH  write word.
REQ-007 SHALL have ports rd_valid  out  1  current read bank full; rd_en  in  1  read request; rd_addr  in  ADDR_W  word address in read bank.
REQ-008 SHALL have ports rd_data  out  DATA_WIDTH  registered read word; rd_data_valid  out  1  rd_data valid; rd_done  in  1  release current read bank.
REQ-009 SHALL have ports wr_bank  out  BANK_W  current write bank index; rd_bank  out  BANK_W  current read bank index; full_count  out  CNT_W  number of FULL banks.

Function
REQ-010 SHALL keep per-bank state EMPTY, FILLING or FULL; wr_ptr and rd_ptr rotate 0..NUM_BANKS-1 with wrap to 0.
REQ-011 SHALL drive wr_ready = 1 iff bank[wr_ptr] is EMPTY or FILLING (combinational from registered state).
REQ-012 SHALL, on wr_valid&&wr_ready, write wr_data to bank[wr_ptr] at wr_addr, increment wr_addr, set bank state FILLING.
REQ-013 SHALL, on the accept at wr_addr==DEPTH-1, set bank FULL, clear wr_addr to 0 and advance wr_ptr, all at that clock edge.
REQ-014 SHALL drive rd_valid = 1 iff bank[rd_ptr] is FULL; rd_valid rises the cycle after the completing write.
REQ-015 SHALL, on rd_en&&rd_valid, present bank[rd_ptr][rd_addr] on rd_data with rd_data_valid=1 exactly one cycle later; unlimited repeated reads of a FULL bank allowed.
REQ-016 SHALL return 0 on rd_data for rd_addr>=DEPTH; SHALL ignore rd_en when rd_valid=0 (rd_data_valid=0 next cycle, rd_data holds).
REQ-017 SHALL, on rd_done&&rd_valid, set bank[rd_ptr] EMPTY and advance rd_ptr; a same-cycle rd_en reads the released bank.
REQ-018 SHALL ignore rd_done when rd_valid=0.
REQ-019 SHALL allow write completion and read release in the same cycle; full_count updates by net change (+1, -1 or 0).
REQ-020 SHALL let a released bank accept writes from the cycle after rd_done (wr_ready rises then when wr_ptr points to it).

Reset
REQ-021 SHALL, on rst, asynchronously set all banks EMPTY, wr_ptr=rd_ptr=wr_addr=0, wr_ready=1, rd_valid=0, rd_data=0, rd_data_valid=0, full_count=0, wr_bank=rd_bank=0.
REQ-022 SHALL NOT clear bank RAM contents on reset; reset mid-fill or mid-read discards all buffered data.

Configuration
REQ-023 SHALL, with macro PP_ERR_EN defined, add output err (1 bit), sticky-set the cycle after rd_en or rd_done while rd_valid=0, or wr_valid while wr_ready=0 for more than 0 cycles is NOT an error; cleared only by rst.
REQ-024 SHALL, without PP_ERR_EN, omit port err and its logic, with those events silently ignored.

Structure
REQ-025 SHALL place bank_state_t enum (EMPTY, FILLING, FULL) and default DATA_WIDTH/DEPTH/NUM_BANKS values in shared package nbank_pp_pkg.
REQ-026 SHALL instantiate per bank one sub-module pp_bank_ram: simple dual-port RAM, one write port, one registered read port, no reset.

Verification
REQ-027 SHALL cover: reset, write 0x0001..0x0008 -> rd_valid=1 and full_count=1 next cycle; rd_en addr 3 -> rd_data=0x0004, rd_data_valid=1 one cycle later.
REQ-028 SHALL cover: 16 writes with no reads -> wr_ready=0 after 16th, full_count=2, 17th word held on wr_data, not accepted.
REQ-029 SHALL cover: then rd_done -> rd_bank=1, wr_ready=1 next cycle, 17th word lands bank 0 addr 0, full_count=1.
REQ-030 SHALL cover: rd_en addr 7 with rd_done same cycle -> rd_data=0x0008 next cycle, bank released, rd_ptr advanced.
REQ-031 SHALL cover: rst after 5 writes -> all outputs at reset values; next 8 writes fill bank 0 from addr 0.
REQ-032 SHALL cover: with PP_ERR_EN, rd_done while rd_valid=0 -> err=1 and stays 1 until rst; without macro, no state change.
